// File: rtl/sprite_animator.sv
// Sprite fetch/render stage: maps the beam into a scaled, mirrored, animated sprite box.
// Optional vertical mirroring (flip_v port) is enabled by defining SPRITE_FLIP_V_EN.
module sprite_animator #(
    parameter int SPR_W           = 32,
    parameter int SPR_H           = 32,
    parameter int NUM_FRAMES      = 4,
    parameter int SCALE_SHIFT     = 1,
    parameter int PIX_BITS        = 4,
    parameter int ROM_LAT         = 1,
    parameter int FRAME_TICKS     = 8,
    parameter int TRANSPARENT_IDX = 0,
    localparam int AW = $clog2(NUM_FRAMES * SPR_W * SPR_H),
    localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic                vga_clk,
    input  logic                Reset,
    input  logic [9:0]          DrawX,
    input  logic [9:0]          DrawY,
    input  logic                blank,
    input  logic                frame_start,
    input  logic [9:0]          pos_x,
    input  logic [9:0]          pos_y,
    input  logic                flip_h,
`ifdef SPRITE_FLIP_V_EN
    input  logic                flip_v,
`endif
    input  logic                anim_en,
    output logic [AW-1:0]       rom_address,
    input  logic [PIX_BITS-1:0] rom_q,
    output logic [PIX_BITS-1:0] pix_idx,
    output logic                pix_valid,
    output logic [FW-1:0]       cur_frame
);

    localparam int TXW   = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int TYW   = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int TW    = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int BOX_W = SPR_W << SCALE_SHIFT;
    localparam int BOX_H = SPR_H << SCALE_SHIFT;

    logic [9:0]          px_q, px_d;
    logic [9:0]          py_q, py_d;
    logic                flip_h_q, flip_h_d;
    logic                flip_v_q, flip_v_d;
    logic [TW-1:0]       tick_q, tick_d;
    logic [FW-1:0]       cur_frame_q, cur_frame_d;
    logic [AW-1:0]       rom_address_q, rom_address_d;
    logic                s0_vld_q, s0_vld_d;
    logic [ROM_LAT-1:0]  vld_dly_q, vld_dly_d;
    logic [PIX_BITS-1:0] pix_idx_q, pix_idx_d;
    logic                pix_valid_q, pix_valid_d;

    logic [10:0]            lx, ly;
    logic                   in_box;
    logic [TXW-1:0]         tx;
    logic [TYW-1:0]         ty;
    logic [FW+TYW+TXW-1:0]  addr_full;

    always_comb begin
        // Shadow geometry only moves at vertical blanking, so a frame never tears.
        px_d     = frame_start ? pos_x  : px_q;
        py_d     = frame_start ? pos_y  : py_q;
        flip_h_d = frame_start ? flip_h : flip_h_q;
`ifdef SPRITE_FLIP_V_EN
        flip_v_d = frame_start ? flip_v : flip_v_q;
`else
        flip_v_d = 1'b0;
`endif

        tick_d      = tick_q;
        cur_frame_d = cur_frame_q;
        if (frame_start && anim_en) begin
            if (tick_q == TW'(FRAME_TICKS - 1)) begin
                tick_d      = '0;
                cur_frame_d = (cur_frame_q == FW'(NUM_FRAMES - 1)) ? '0 : cur_frame_q + 1'b1;
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end

        // 11-bit difference keeps the sign, so boxes past the screen edge clip instead of wrapping.
        lx     = {1'b0, DrawX} - {1'b0, px_q};
        ly     = {1'b0, DrawY} - {1'b0, py_q};
        in_box = ~lx[10] & ~ly[10] & (lx < 11'(BOX_W)) & (ly < 11'(BOX_H));

        tx = TXW'(lx >> SCALE_SHIFT);
        ty = TYW'(ly >> SCALE_SHIFT);
        if (flip_h_q) tx = ~tx;
        if (flip_v_q) ty = ~ty;

        addr_full     = {cur_frame_q, ty, tx};
        rom_address_d = in_box ? addr_full[AW-1:0] : rom_address_q;
        s0_vld_d      = in_box & blank;

        vld_dly_d[0] = s0_vld_q;
        for (int i = 1; i < ROM_LAT; i++) begin
            vld_dly_d[i] = vld_dly_q[i-1];
        end

        pix_valid_d = vld_dly_q[ROM_LAT-1] & (rom_q != PIX_BITS'(TRANSPARENT_IDX));
        pix_idx_d   = pix_valid_d ? rom_q : '0;
    end

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            px_q          <= '0;
            py_q          <= '0;
            flip_h_q      <= 1'b0;
            flip_v_q      <= 1'b0;
            tick_q        <= '0;
            cur_frame_q   <= '0;
            rom_address_q <= '0;
            s0_vld_q      <= 1'b0;
            vld_dly_q     <= '0;
            pix_idx_q     <= '0;
            pix_valid_q   <= 1'b0;
        end else begin
            px_q          <= px_d;
            py_q          <= py_d;
            flip_h_q      <= flip_h_d;
            flip_v_q      <= flip_v_d;
            tick_q        <= tick_d;
            cur_frame_q   <= cur_frame_d;
            rom_address_q <= rom_address_d;
            s0_vld_q      <= s0_vld_d;
            vld_dly_q     <= vld_dly_d;
            pix_idx_q     <= pix_idx_d;
            pix_valid_q   <= pix_valid_d;
        end
    end

    assign rom_address = rom_address_q;
    assign pix_idx     = pix_idx_q;
    assign pix_valid   = pix_valid_q;
    assign cur_frame   = cur_frame_q;

endmodule

// File: doc/sprite_animator.md
Name: sprite_animator

Overview:
- Parametrised sprite fetch/render stage for the VGA pipeline.
- Maps the beam position (DrawX, DrawY) into a movable, integer-scaled, optionally mirrored sprite box.
- Addresses an external multi-frame sprite ROM, compensates for the ROM read latency and advances animation frames on vertical-sync boundaries.
- Emits a palette index plus a valid/opaque flag to the colour mux; the palette itself stays external.

Parameters:
- SPR_W, 32: sprite width in texels; power of two.
- SPR_H, 32: sprite height in texels; power of two.
- NUM_FRAMES, 4: animation frames stored back-to-back in ROM.
- SCALE_SHIFT, 1: on-screen scale is 2^SCALE_SHIFT pixels per texel.
- PIX_BITS, 4: ROM data (palette index) width.
- ROM_LAT, 1: ROM read latency in vga_clk cycles; must be 1 or more.
- FRAME_TICKS, 8: frame_start pulses per animation frame.
- TRANSPARENT_IDX, 0: palette index treated as transparent.

Ports:
- vga_clk  in  1  pixel clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- DrawX  in  10  beam column
- DrawY  in  10  beam row
- blank  in  1  1 = active video
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- pos_x  in  10  requested sprite top-left column
- pos_y  in  10  requested sprite top-left row
- flip_h  in  1  requested horizontal mirror
- anim_en  in  1  1 = animation advances
- rom_address  out  AW = $clog2(NUM_FRAMES*SPR_W*SPR_H)  registered ROM address
- rom_q  in  PIX_BITS  ROM data, valid ROM_LAT cycles after rom_address
- pix_idx  out  PIX_BITS  palette index
- pix_valid  out  1  sprite covers this pixel and the pixel is opaque
- cur_frame  out  $clog2(NUM_FRAMES)  current animation frame

Behaviour:
- Reset (synchronous, active-high):
  - rom_address, pix_idx, pix_valid, cur_frame, tick counter and pipeline valids all clear to 0.
  - Latched position and flip also clear to 0.
- Shadow latch:
  - pos_x, pos_y and flip_h are captured into shadow registers only on a cycle where frame_start = 1.
  - Geometry never changes mid-frame, so there is no tearing.
- Stage 0 (address), registered:
  - Compute lx = DrawX - px and ly = DrawY - py in 11-bit arithmetic.
  - in_box = lx and ly non-negative, lx < SPR_W<<SCALE_SHIFT, ly < SPR_H<<SCALE_SHIFT.
  - Texel coordinates: tx = lx>>SCALE_SHIFT, ty = ly>>SCALE_SHIFT; when flip is set, tx = SPR_W-1-tx.
  - rom_address = cur_frame*SPR_W*SPR_H + ty*SPR_W + tx when in_box, otherwise it holds its previous value.
  - in_box & blank is delayed alongside the address.
- Delay stages:
  - in_box & blank passes through ROM_LAT delay registers to align with rom_q.
- Output stage, registered:
  - pix_idx = rom_q.
  - pix_valid = delayed(in_box & blank) & (rom_q != TRANSPARENT_IDX).
  - When pix_valid = 0, pix_idx is forced to 0.
- Latency: outputs correspond to the DrawX/DrawY presented exactly ROM_LAT+2 cycles earlier.
- Clipping:
  - A box extending past column 639 or row 479 is clipped; coordinates never wrap.
  - A box with px > 639 is never visible.
- Animation counter:
  - On frame_start & anim_en: if tick = FRAME_TICKS-1, tick goes to 0 and cur_frame goes to (cur_frame+1) mod NUM_FRAMES; otherwise tick increments.
  - anim_en = 0 freezes both tick and cur_frame.
  - A frame change takes effect at the next Stage 0 evaluation, which falls inside vertical blanking.
- Reset asserted mid-line: pipeline valids clear on that edge, and pix_valid is 0 from the next cycle until ROM_LAT+2 cycles after Reset deasserts.

Optional Feature:
- Macro: SPRITE_FLIP_V_EN.
- With the macro defined:
  - Adds input port flip_v (1 bit), latched on frame_start like flip_h.
  - When set, ty = SPR_H-1-ty.
- Without the macro: the port is absent and there is no vertical mirroring.

Test Plan:
- Basic fetch (defaults; pos_x=100, pos_y=50 latched on frame_start; cur_frame=0):
  - DrawX=100, DrawY=50, blank=1 -> rom_address=0 one cycle later; pix_idx=rom_q 3 cycles later.
  - DrawX=163, DrawY=113 -> rom_address=1023.
  - DrawX=164 -> pix_valid=0 at 3 cycles.
- Transparency and blank:
  - rom_q=0 at an in-box pixel -> pix_valid=0, pix_idx=0.
  - rom_q=5 with blank=0 -> pix_valid=0.
- Flip: flip_h=1 latched, DrawX=100, DrawY=50 -> rom_address=31; changing flip_h mid-frame without frame_start -> no effect.
- Animation, anim_en=1:
  - 8 frame_start pulses -> cur_frame=1, and DrawX=100, DrawY=50 gives rom_address=1024.
  - 32 pulses -> cur_frame wraps to 0.
  - anim_en=0 for 20 pulses -> cur_frame unchanged.
- Clipping and reset:
  - pos_x=620 -> DrawX=639 valid; no pixel at DrawX=0 on that row.
  - Reset pulsed mid-line -> pix_valid, cur_frame, rom_address are 0 on the following cycle.
- SPRITE_FLIP_V_EN build: flip_v=1 latched, DrawX=100, DrawY=50 -> rom_address=992.
